// File: rtl/sram_like_data_slave_if.sv
// sram-like data-side bus between the CPU's EXE/MEM stages and a data RAM.
// The master drives requests; the slave answers with addr_ok/data_ok/rdata.
interface sram_like_data_slave_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr,
    output data_sram_size, data_sram_wstrb,
    output data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr,
    input  data_sram_size, data_sram_wstrb,
    input  data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok,
    output data_sram_rdata
  );
endinterface

// File: rtl/sram_like_data_slave.sv
// sram-like data RAM responder: fixed-latency, in-order pipelined
// responses from a word-addressed memory, with a stall hook.
module sram_like_data_slave #(
  parameter int MEM_AW  = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic stall,
  sram_like_data_slave_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] LAT = 3'(LATENCY);
  localparam logic [2:0] MAT = 3'(LATENCY - 1);
  localparam logic [2:0] DEP = 3'(DEPTH);

  typedef struct packed {
    logic        is_load;
    logic [31:0] rdata;
    logic [2:0]  age;
  } ent_t;

  logic [31:0] mem [2**MEM_AW];
  ent_t        q [DEPTH];
  logic [PW-1:0] head, tail, head_n;
  logic [2:0]  count, count_n;
  logic        dok_q, dok_n;
  logic [31:0] rdata_q;

  logic [MEM_AW-1:0] widx;
  logic        addr_ok, accept, retire, fresh;
  logic [2:0]  head_age_n;
  logic        head_load_n;
  logic [31:0] head_data_n;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [2:0] grow(
    input logic [2:0] a
  );
    return (a >= LAT) ? LAT : a + 3'd1;
  endfunction

  assign widx    = bus.data_sram_addr[MEM_AW+1:2];
  assign addr_ok = resetn && !stall && (count < DEP);
  assign accept  = bus.data_sram_req && addr_ok;
  assign retire  = dok_q;

  wire unused = ^{bus.data_sram_size,
                  bus.data_sram_addr[31:MEM_AW+2],
                  bus.data_sram_addr[1:0]};

  // fresh: the request accepted this edge becomes the new head
  always_comb begin
    head_n      = retire ? nxt(head) : head;
    count_n     = count + 3'(accept) - 3'(retire);
    fresh       = accept && (count == 3'(retire));
    head_age_n  = fresh ? 3'd0 : grow(q[head_n].age);
    head_load_n = fresh ? !bus.data_sram_wr
                        : q[head_n].is_load;
    head_data_n = fresh ? mem[widx] : q[head_n].rdata;
    dok_n       = (count_n != 3'd0) && !stall &&
                  (head_age_n >= MAT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      dok_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        q[i].age <= grow(q[i].age);
      if (accept) begin
        q[tail].is_load <= !bus.data_sram_wr;
        q[tail].rdata   <= mem[widx];
        q[tail].age     <= 3'd0;
        tail            <= nxt(tail);
      end
      head  <= head_n;
      count <= count_n;
      dok_q <= dok_n;
      if (dok_n)
        rdata_q <= head_load_n ? head_data_n : '0;
    end
  end

  // memory contents are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (accept && bus.data_sram_wr) begin
      for (int b = 0; b < 4; b++)
        if (bus.data_sram_wstrb[b])
          mem[widx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
    end
  end

  assign bus.data_sram_addr_ok = addr_ok;
  assign bus.data_sram_data_ok = dok_q;
  assign bus.data_sram_rdata   = rdata_q;

endmodule

// File: tb/tb_sram_like_data_slave.sv
// Bench for sram_like_data_slave: two instances (LATENCY 2 and 1)
// checked every cycle against a request-level reference model.
`timescale 1ns/1ps
module tb_sram_like_data_slave;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic resetn;
  logic stall;
  logic        req   [2];
  logic        wr    [2];
  logic [3:0]  strb  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        aok   [2];
  logic        dok   [2];
  logic [31:0] rdat  [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  sram_like_data_slave_if bi [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign bi[g].data_sram_req   = req[g];
    assign bi[g].data_sram_wr    = wr[g];
    assign bi[g].data_sram_size  = 2'd2;
    assign bi[g].data_sram_wstrb = strb[g];
    assign bi[g].data_sram_addr  = addr[g];
    assign bi[g].data_sram_wdata = wdata[g];
    assign aok[g]  = bi[g].data_sram_addr_ok;
    assign dok[g]  = bi[g].data_sram_data_ok;
    assign rdat[g] = bi[g].data_sram_rdata;
    sram_like_data_slave #(
      .MEM_AW(10), .LATENCY(g == 0 ? 2 : 1), .DEPTH(DEPTH)
    ) u_dut (
      .clk(clk), .resetn(resetn), .stall(stall), .bus(bi[g])
    );
  end

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d cyc%0d got %h want %h",
               nm, i, cyc, act, exp);
    end
  endtask

  // reference model: byte memory with known-mask, pending FIFO
  bit [7:0]    mb [2][4096];
  bit          kn [2][4096];
  int          pacc [2][16];
  logic [31:0] pdat [2][16];
  logic [31:0] pmsk [2][16];
  int          ph [2];
  int          pt [2];
  bit          stall_prev = 1'b0;
  bit          acc_flag [2];
  int          acc_cyc [2];
  int          dlc [2][256];
  logic [31:0] dld [2][256];
  int          ndl [2];

  logic        m_ea, m_ed;
  int          m_h, m_t, m_bi;
  logic [31:0] m_d, m_m;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      acc_flag[i] = 1'b0;
      if (!resetn) begin
        chk("reset_addr_ok", i, 32'(aok[i]), 32'd0);
        chk("reset_data_ok", i, 32'(dok[i]), 32'd0);
        chk("reset_rdata", i, rdat[i], 32'd0);
        ph[i] = 0;
        pt[i] = 0;
      end else begin
        m_h  = ph[i] % 16;
        m_ea = !stall && ((pt[i] - ph[i]) < DEPTH);
        m_ed = (pt[i] != ph[i]) && !stall_prev &&
               (cyc >= pacc[i][m_h] + lat_of(i));
        chk("addr_ok", i, 32'(aok[i]), 32'(m_ea));
        chk("data_ok", i, 32'(dok[i]), 32'(m_ed));
        if (dok[i]) begin
          dlc[i][ndl[i] % 256] = cyc;
          dld[i][ndl[i] % 256] = rdat[i];
          ndl[i]++;
        end
        if (m_ed) begin
          chk("rdata", i, rdat[i] & pmsk[i][m_h],
              pdat[i][m_h] & pmsk[i][m_h]);
          ph[i]++;
        end
        if (req[i] && m_ea) begin
          m_t = pt[i] % 16;
          m_d = '0;
          m_m = '1;
          for (int b = 0; b < 4; b++) begin
            m_bi = int'(addr[i][11:2]) * 4 + b;
            if (wr[i]) begin
              if (strb[i][b]) begin
                mb[i][m_bi] = wdata[i][8*b +: 8];
                kn[i][m_bi] = 1'b1;
              end
            end else begin
              m_d[8*b +: 8] = mb[i][m_bi];
              m_m[8*b +: 8] = kn[i][m_bi] ? 8'hFF : 8'h00;
            end
          end
          pacc[i][m_t] = cyc;
          pdat[i][m_t] = m_d;
          pmsk[i][m_t] = m_m;
          pt[i]++;
          acc_flag[i] = 1'b1;
          acc_cyc[i]  = cyc;
        end
      end
    end
    stall_prev = stall;
    cyc++;
  end

  // all driver tasks are entered 1ns after a rising edge
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input bit w,
                      input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, output int ac);
    req[i] = 1'b1; wr[i] = w; strb[i] = s;
    addr[i] = a; wdata[i] = d;
    ac = -1;
    for (int k = 0; k < 50 && ac < 0; k++) begin
      @(posedge clk);
      if (acc_flag[i]) ac = acc_cyc[i];
      #1;
    end
    if (ac < 0) chk("accept_timeout", i, 32'd0, 32'd1);
  endtask

  task automatic chk_log(input string nm, input int i, input int k,
                         input int ec, input logic [31:0] ed);
    chk({nm, "_cycle"}, i, 32'(dlc[i][k % 256]), 32'(ec));
    chk({nm, "_data"}, i, dld[i][k % 256], ed);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog inst0 got timeout want finish");
    $fatal(1);
  end

  int a0, a1, a2, n0, first, dummy;
  logic [31:0] ra;

  initial begin
    resetn = 1'b0; stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; strb[i] = '0;
      addr[i] = '0; wdata[i] = '0; ndl[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    cycles(2);

    // store/load round trip at LATENCY 2
    n0 = ndl[0];
    send(0, 1, 4'hF, 32'h100, 32'h12345678, a0);
    send(0, 0, 4'h0, 32'h100, 32'h0, a1);
    req[0] = 1'b0;
    cycles(5);
    chk("t1_b2b", 0, 32'(a1), 32'(a0 + 1));
    chk_log("t1_st", 0, n0, a0 + 2, 32'h0);
    chk_log("t1_ld", 0, n0 + 1, a1 + 2, 32'h12345678);

    // single-lane store merges into the existing word
    n0 = ndl[0];
    send(0, 1, 4'h4, 32'h100, 32'hAABBCCDD, a0);
    send(0, 0, 4'h0, 32'h100, 32'h0, a1);
    req[0] = 1'b0;
    cycles(5);
    chk_log("t2_ld", 0, n0 + 1, a1 + 2, 32'h12BB5678);

    // three held loads against DEPTH 2
    send(0, 1, 4'hF, 32'h104, 32'h11111111, dummy);
    send(0, 1, 4'hF, 32'h108, 32'h22222222, dummy);
    req[0] = 1'b0;
    cycles(5);
    n0 = ndl[0];
    send(0, 0, 4'h0, 32'h100, 32'h0, a0);
    send(0, 0, 4'h0, 32'h104, 32'h0, a1);
    send(0, 0, 4'h0, 32'h108, 32'h0, a2);
    req[0] = 1'b0;
    cycles(6);
    chk("t3_acc2", 0, 32'(a1), 32'(a0 + 1));
    chk("t3_acc3", 0, 32'(a2), 32'(a0 + 3));
    chk_log("t3_r0", 0, n0, a0 + 2, 32'h12BB5678);
    chk_log("t3_r1", 0, n0 + 1, a0 + 3, 32'h11111111);
    chk_log("t3_r2", 0, n0 + 2, a0 + 5, 32'h22222222);

    // stall before maturity holds the response
    n0 = ndl[0];
    send(0, 0, 4'h0, 32'h104, 32'h0, a0);
    req[0] = 1'b0;
    stall = 1'b1;
    cycles(5);
    stall = 1'b0;
    cycles(4);
    chk("t4_count", 0, 32'(ndl[0]), 32'(n0 + 1));
    chk_log("t4_ld", 0, n0, a0 + 7, 32'h11111111);

    // asynchronous reset with two requests in flight
    send(0, 0, 4'h0, 32'h100, 32'h0, a0);
    send(0, 0, 4'h0, 32'h104, 32'h0, a1);
    req[0] = 1'b0;
    n0 = ndl[0];
    ra = rdat[0];
    #1 resetn = 1'b0;
    #1;
    chk("t5_rdata_pre", 0, 32'(ra != 0), 32'd1);
    chk("t5_aok_now", 0, 32'(aok[0]), 32'd0);
    chk("t5_dok_now", 0, 32'(dok[0]), 32'd0);
    chk("t5_rdata_now", 0, rdat[0], 32'd0);
    #4 resetn = 1'b1;
    cycles(4);
    chk("t5_dropped", 0, 32'(ndl[0]), 32'(n0));
    send(0, 0, 4'h0, 32'h108, 32'h0, a0);
    req[0] = 1'b0;
    cycles(4);
    chk_log("t5_ld", 0, n0, a0 + 2, 32'h22222222);

    // LATENCY 1, wrapping addresses, bit 12 ignored
    n0 = ndl[1];
    for (int k = 0; k < 8; k++) begin
      send(1, 1, 4'hF, (k % 2 == 0) ? 32'hFFC : 32'h1000,
           32'hC0DE0000 + k, a0);
      if (k == 0) first = a0;
      send(1, 0, 4'h0, (k % 2 == 0) ? 32'hFFC : 32'h0,
           32'h0, a1);
    end
    req[1] = 1'b0;
    cycles(4);
    chk("t6_stream", 1, 32'(a1), 32'(first + 15));
    for (int j = 0; j < 16; j++)
      chk_log("t6_rsp", 1, n0 + j, first + 1 + j,
              (j % 2 == 1) ? 32'hC0DE0000 + 32'(j / 2) : 32'h0);

    // randomized traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        req[i]   = ($urandom_range(0, 3) != 0);
        wr[i]    = $urandom_range(0, 1) == 1;
        strb[i]  = ($urandom_range(0, 2) == 0) ? 4'hF
                                                : 4'($urandom);
        addr[i]  = ($urandom & 32'hFFFF_F003) |
                   (32'hFC0 + 32'($urandom_range(0, 31)) * 4 & 32'hFFC);
        wdata[i] = $urandom;
      end
      stall = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) begin
        req[0] = 1'b0;
        req[1] = 1'b0;
        #1 resetn = 1'b0;
        #5 resetn = 1'b1;
      end
      cycles(1);
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    stall = 1'b0;
    cycles(10);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_like_data_slave.md
Name: sram_like_data_slave

Overview:
- Responder end of the sram-like data-side interface: accepts load/store requests from the CPU's EXE/MEM pipeline and returns addr_ok, data_ok and rdata.
- Backed by an internal word-addressed memory. Supports a configurable fixed response latency, in-order pipelined outstanding requests, and a stall input for back-pressure tests.
- Serves as the data-RAM model for core simulation and as the template for the later sram-like-to-AXI bridge.

Parameters:
- MEM_AW, 10: memory word-address width (2^MEM_AW 32-bit words).
- LATENCY, 2: cycles from acceptance to earliest data_ok (legal range 1..7).
- DEPTH, 2: maximum outstanding accepted-but-unanswered requests (legal 1..4).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1 = store, 0 = load.
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word (informational; byte enables come from wstrb).
- data_sram_wstrb  in  4  store byte enables (covers sb/sh/sw/swl/swr).
- data_sram_addr  in  32  byte address; word index = addr[MEM_AW+1:2], higher bits ignored.
- data_sram_wdata  in  32  store data, already lane-aligned by the master.
- data_sram_addr_ok  out  1  request accepted this cycle when req && addr_ok.
- data_sram_data_ok  out  1  one-cycle response pulse, strictly in acceptance order.
- data_sram_rdata  out  32  full aligned word for loads (master does lane extraction); 0 for store responses.
- stall  in  1  test hook: forces addr_ok = 0 and holds the response queue.

Behaviour:
- Reset (resetn low, asynchronous):
  - addr_ok = 0, data_ok = 0, rdata = 0.
  - Queue emptied; pending count = 0.
  - Memory contents are not reset (undefined unless preloaded by the bench).
- Reset deasserted mid-operation: all in-flight requests are dropped, no data_ok is issued for them, and addr_ok resumes on the first cycle after release.
- addr_ok = !stall && count < DEPTH (registered count only; no combinational path from data_ok to addr_ok).
- Acceptance in cycle n (req && addr_ok):
  - Store: each byte i with wstrb[i] = 1 is written at edge n; bytes with wstrb[i] = 0 are preserved.
  - Load: the memory word is sampled at edge n into the queue entry, so a later store cannot alter an earlier load's data and an earlier store is visible to a later load.
  - A store with wstrb = 0 is accepted, modifies nothing, and still gets data_ok.
- Queue: circular buffer of DEPTH entries, each holding {is_load, rdata, age[2:0]}.
  - age starts at 0 and increments each cycle, saturating at LATENCY.
  - Head pointer and tail pointer wrap modulo DEPTH.
- Response:
  - data_ok = 1 in a cycle when the head entry is valid, head.age == LATENCY-1 or saturated, and stall = 0.
  - data_ok is registered, so its earliest assertion is cycle n+LATENCY.
  - The head retires at the edge ending a data_ok cycle.
  - At most one data_ok per cycle; back-to-back acceptances yield back-to-back data_ok pulses.
- Simultaneous acceptance and retirement in one cycle: count unchanged, both pointers advance.
- Full (count == DEPTH): addr_ok = 0 until a retirement edge; a new acceptance is possible in the following cycle.
- Empty: data_ok = 0; rdata holds its last value (don't-care to the master).
- Stall:
  - Ages keep advancing, but retirement is blocked.
  - On stall release, the head's data_ok is issued in the next cycle if its age is mature.
- Misaligned address vs size: no error. The slave has no exception path; the core raises AdEL/AdES before issuing the request.
- No cancel input: every accepted request receives exactly one data_ok, including after a pipeline flush. The master is responsible for discarding stale responses.

Test Plan:
1. Store 0x12345678 to 0x100 with wstrb = 4'hF, then load 0x100 → data_ok at acceptance+2 (LATENCY = 2) for both; load rdata = 0x12345678.
2. Store 0xAABBCCDD with wstrb = 4'h4 to 0x100 (memory 0x12345678), then load → rdata = 0x12BB5678.
3. Three back-to-back loads with DEPTH = 2 and req held high → addr_ok drops on the third request until the first data_ok retires; data_ok pulses arrive in order with matching data.
4. Accept a load, then raise stall for 5 cycles before maturity → no data_ok while stalled; data_ok arrives in the cycle after stall falls; addr_ok is 0 throughout the stall.
5. Accept two requests, then pulse resetn low asynchronously mid-cycle → addr_ok, data_ok and rdata go to 0 immediately; no data_ok follows for dropped requests; a new load after release returns the correct data at LATENCY.
6. LATENCY = 1 with 8 alternating load/store pairs to wrapping addresses 0xFFC → 0x000 (MEM_AW = 10, addr bit 12 ignored) → one data_ok per cycle after the first, and loads reflect the immediately preceding store.
